// File: rtl/multi_dataflow_roberts_mdc_engine_pkg.sv
// Shared types for the Roberts-cross engine: control/flag bundles,
// FSM encoding and the default line-buffer depth.
package multi_dataflow_roberts_mdc_package;

   localparam int unsigned ROBERTS_MAX_WIDTH = 512;

   typedef struct packed {
      logic start;
   } ctrl_engine_multi_dataflow_roberts_mdc_t;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        err;
      logic [31:0] out_cnt;
   } flags_engine_multi_dataflow_roberts_mdc_t;

   typedef enum logic [2:0] {
      IDLE,
      SIZE,
      RUN,
      DRAIN,
      DONE
   } roberts_state_e;

endpackage

// File: rtl/multi_dataflow_roberts_mdc_engine_if.sv
// Valid/ready stream bundle used for the size word, pixels and
// gradient output.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport source (
      output valid, data, strb,
      input  ready
   );

   modport sink (
      input  valid, data, strb,
      output ready
   );

endinterface

// File: rtl/multi_dataflow_roberts_mdc_engine_line_buffer.sv
// Previous-row pixel store: one port, combinational read,
// contents intentionally left unreset.
module multi_dataflow_roberts_mdc_line_buffer #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 9
) (
   input  logic             clk_i,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/multi_dataflow_roberts_mdc_engine.sv
// Streaming Roberts-cross engine: size word, raster pixels in,
// saturated gradient magnitude out for every pixel with x>=1, y>=1.
module multi_dataflow_roberts_mdc_engine
   import multi_dataflow_roberts_mdc_package::*;
#(
   parameter int unsigned MAX_WIDTH = ROBERTS_MAX_WIDTH,
   parameter int unsigned PEL_WIDTH = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic test_mode_i,
   input  logic enable_i,
   input  logic clear_i,
   hwpe_stream_intf_stream.sink   in_size,
   hwpe_stream_intf_stream.sink   in_pel,
   hwpe_stream_intf_stream.source out_pel,
   input  ctrl_engine_multi_dataflow_roberts_mdc_t  ctrl_i,
   output flags_engine_multi_dataflow_roberts_mdc_t flags_o
);

   localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [15:0] W_MAX = 16'(MAX_WIDTH);
   localparam logic [PEL_WIDTH-1:0] SAT = '1;

   roberts_state_e state;
   logic [15:0] w, h, x, y, sw, sh;
   logic [PEL_WIDTH-1:0] pel, up, up_left, left;
   logic [PEL_WIDTH-1:0] out_data, grad, a0, a1;
   logic [PEL_WIDTH:0] sum;
   logic [31:0] out_cnt;
   logic out_valid, err;
   logic size_hs, pel_hs, out_hs;
   logic size_ok, last_x, last_y, emit;
   logic unused_bits;

   assign pel = in_pel.data[PEL_WIDTH-1:0];
   assign sw  = in_size.data[15:0];
   assign sh  = in_size.data[31:16];

   assign in_size.ready = enable_i && (state == SIZE);
   assign in_pel.ready  = enable_i && (state == RUN)
                        && (!out_valid || out_pel.ready);

   assign size_hs = in_size.valid && in_size.ready;
   assign pel_hs  = in_pel.valid && in_pel.ready;
   assign out_hs  = enable_i && out_valid && out_pel.ready;

   assign size_ok = (sw >= 16'd2) && (sw <= W_MAX) && (sh >= 16'd2);
   assign last_x  = (x == w - 16'd1);
   assign last_y  = (y == h - 16'd1);
   assign emit    = (x != '0) && (y != '0);

   // |a-b| on unsigned pixels equals the 9-bit signed difference magnitude
   always_comb begin
      a0   = (pel >= up_left) ? pel - up_left : up_left - pel;
      a1   = (left >= up) ? left - up : up - left;
      sum  = {1'b0, a0} + {1'b0, a1};
      grad = sum[PEL_WIDTH] ? SAT : sum[PEL_WIDTH-1:0];
   end

   multi_dataflow_roberts_mdc_line_buffer #(
      .DEPTH (MAX_WIDTH),
      .WIDTH (PEL_WIDTH),
      .AW    (AW)
   ) u_lb (
      .clk_i (clk_i),
      .we    (pel_hs),
      .addr  (x[AW-1:0]),
      .wdata (pel),
      .rdata (up)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state     <= IDLE;
         w         <= '0;
         h         <= '0;
         x         <= '0;
         y         <= '0;
         up_left   <= '0;
         left      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
         err       <= 1'b0;
      end else if (enable_i) begin
         if (out_hs) out_valid <= 1'b0;
         unique case (state)
            IDLE: if (ctrl_i.start) begin
               err     <= 1'b0;
               out_cnt <= '0;
               state   <= SIZE;
            end
            SIZE: if (size_hs) begin
               w <= sw;
               h <= sh;
               x <= '0;
               y <= '0;
               if (size_ok) begin
                  state <= RUN;
               end else begin
                  err   <= 1'b1;
                  state <= DONE;
               end
            end
            RUN: if (pel_hs) begin
               up_left <= up;
               left    <= pel;
               if (emit) begin
                  out_valid <= 1'b1;
                  out_data  <= grad;
                  out_cnt   <= out_cnt + 32'd1;
               end
               if (last_x) begin
                  x <= '0;
                  y <= y + 16'd1;
               end else begin
                  x <= x + 16'd1;
               end
               if (last_x && last_y) state <= DRAIN;
            end
            DRAIN: if (!out_valid) state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign out_pel.valid = out_valid;
   assign out_pel.data  = {{(32-PEL_WIDTH){1'b0}}, out_data};
   assign out_pel.strb  = '1;

   assign flags_o.busy    = (state != IDLE);
   assign flags_o.done    = (state == DONE);
   assign flags_o.err     = err;
   assign flags_o.out_cnt = out_cnt;

   assign unused_bits = ^{test_mode_i, in_size.strb, in_pel.strb,
                          in_pel.data[31:PEL_WIDTH]};

endmodule

// File: tb/tb_multi_dataflow_roberts_mdc_engine.sv
// Randomized bench for the Roberts-cross engine with a frame-level
// gradient model and per-cycle output checking.
module tb_multi_dataflow_roberts_mdc_engine;
   import multi_dataflow_roberts_mdc_package::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic enable = 1'b1;
   logic test_mode = 1'b0;
   ctrl_engine_multi_dataflow_roberts_mdc_t  ctrl;
   flags_engine_multi_dataflow_roberts_mdc_t flags;

   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) size_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pel_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

   always #5 clk = ~clk;

   multi_dataflow_roberts_mdc_engine #(
      .MAX_WIDTH (512),
      .PEL_WIDTH (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .test_mode_i (test_mode),
      .enable_i    (enable),
      .clear_i     (clear),
      .in_size     (size_if),
      .in_pel      (pel_if),
      .out_pel     (out_if),
      .ctrl_i      (ctrl),
      .flags_o     (flags)
   );

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int stall_cnt = 0;
   bit rnd_ready = 0;
   bit pel_ready_seen = 0;
   int pix[$];
   int exp_q[$];
   int got_q[$];
   logic pv = 1'b0, pr = 1'b0, pc = 1'b1;
   logic [31:0] pd = '0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Gradient of every pixel with an upper and left neighbour, raster order
   function automatic void gen_expected(input int w, input int h);
      int g;
      exp_q.delete();
      for (int yy = 1; yy < h; yy++)
         for (int xx = 1; xx < w; xx++) begin
            g = absd(pix[yy*w+xx], pix[(yy-1)*w+xx-1])
              + absd(pix[yy*w+xx-1], pix[(yy-1)*w+xx]);
            exp_q.push_back(g > 255 ? 255 : g);
         end
   endfunction

   task automatic pulse_start();
      step();
      ctrl.start = 1'b1;
      step();
      ctrl.start = 1'b0;
   endtask

   task automatic send_size(input int w, input int h);
      int t = 0;
      step();
      size_if.valid = 1'b1;
      size_if.data  = {16'(h), 16'(w)};
      forever begin
         #3;
         if (size_if.ready) break;
         t++;
         if (t > 50) begin
            chk("size_timeout", 0, 1);
            break;
         end
         step();
      end
      step();
      size_if.valid = 1'b0;
   endtask

   task automatic send_pixels(input int n, input bit gaps,
                              input int stall_at);
      int t;
      for (int i = 0; i < n; i++) begin
         step();
         if (gaps && $urandom_range(3) == 0) begin
            pel_if.valid = 1'b0;
            step();
         end
         pel_if.valid = 1'b1;
         pel_if.data  = 32'(pix[i]);
         t = 0;
         forever begin
            #3;
            if (pel_if.ready) break;
            t++;
            if (t > 200) begin
               chk("pel_timeout", 0, 1);
               pel_if.valid = 1'b0;
               return;
            end
            step();
         end
         if (i == stall_at) stall_cnt = 5;
      end
      step();
      pel_if.valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      forever begin
         @(negedge clk);
         #3;
         if (flags.done) break;
         t++;
         if (t > budget) begin
            chk("done_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic run_frame(input int w, input int h, input bit gaps,
                            input int stall_at);
      int d0;
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      send_size(w, h);
      send_pixels(w*h, gaps, stall_at);
      wait_done(8*w*h + 100);
      step();
      chk("done_pulses", 64'(done_cnt - d0), 1);
      chk("out_cnt", flags.out_cnt, 64'((w-1)*(h-1)));
      chk("err_clear", flags.err, 0);
      chk("pending_out", 64'(exp_q.size()), 0);
   endtask

   task automatic fill_3y_x();
      pix.delete();
      for (int i = 0; i < 9; i++) pix.push_back(3*(i/3) + i%3);
   endtask

   // Output sink: ready is forced low during a stall window, else random/high
   initial begin
      out_if.ready = 1'b0;
      forever begin
         step();
         if (stall_cnt > 0) begin
            out_if.ready = 1'b0;
            stall_cnt--;
         end else if (rnd_ready) begin
            out_if.ready = ($urandom_range(3) != 0);
         end else begin
            out_if.ready = 1'b1;
         end
      end
   end

   initial begin
      int e;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n) begin
            if (pv && !pr && !pc) begin
               chk("hold_valid", out_if.valid, 1);
               chk("hold_data", out_if.data, pd);
            end
            if (out_if.valid && !out_if.ready)
               chk("stall_in_ready", pel_if.ready, 0);
            if (out_if.valid && out_if.ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_if.data, 64'(e));
                  got_q.push_back(int'(out_if.data));
               end
            end
            if (pel_if.ready) pel_ready_seen = 1;
            if (flags.done) done_cnt++;
         end
         pv = out_if.valid;
         pr = out_if.ready;
         pd = out_if.data;
         pc = clear || !rst_n;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, h, d0;
      ctrl = '0;
      size_if.valid = 1'b0;
      size_if.data  = '0;
      size_if.strb  = '1;
      pel_if.valid  = 1'b0;
      pel_if.data   = '0;
      pel_if.strb   = '1;

      repeat (3) step();
      #2;
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_out_data", out_if.data, 0);
      chk("rst_out_strb", out_if.strb, 4'hf);
      chk("rst_flags", flags, 0);
      chk("rst_size_ready", size_if.ready, 0);
      chk("rst_pel_ready", pel_if.ready, 0);
      step();
      rst_n = 1'b1;

      fill_3y_x();
      gen_expected(3, 3);
      chk("model_3x3_n", 64'(exp_q.size()), 4);
      chk("model_3x3_v", 64'(exp_q[3]), 6);
      run_frame(3, 3, 0, -1);

      pix = '{0, 0, 255, 255};
      gen_expected(2, 2);
      chk("model_sat", 64'(exp_q[0]), 255);
      run_frame(2, 2, 0, -1);

      pel_ready_seen = 0;
      pulse_start();
      send_size(1, 5);
      #2;
      chk("bad_done", flags.done, 1);
      chk("bad_err", flags.err, 1);
      step();
      #2;
      chk("bad_done_once", flags.done, 0);
      chk("bad_busy", flags.busy, 0);
      repeat (5) step();
      chk("bad_pel_ready", pel_ready_seen, 0);
      chk("err_sticky", flags.err, 1);

      fill_3y_x();
      gen_expected(3, 3);
      run_frame(3, 3, 0, 4);
      chk("stall_seq", 64'(got_q.size() == 4 && got_q[0] == 6
                            && got_q[3] == 6), 1);

      pix.delete();
      for (int i = 0; i < 16; i++) pix.push_back($urandom_range(255));
      d0 = done_cnt;
      pulse_start();
      send_size(4, 4);
      send_pixels(4, 0, -1);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      #2;
      chk("clr_busy", flags.busy, 0);
      chk("clr_valid", out_if.valid, 0);
      chk("clr_flags", flags, 0);
      repeat (4) step();
      chk("clr_no_done", 64'(done_cnt - d0), 0);
      fill_3y_x();
      gen_expected(3, 3);
      run_frame(3, 3, 0, -1);

      pix.delete();
      for (int i = 0; i < 512; i++) pix.push_back(i % 256);
      for (int i = 0; i < 512; i++) pix.push_back((i + 1) % 256);
      gen_expected(512, 2);
      chk("model_ramp_x1", 64'(exp_q[0]), 2);
      chk("model_ramp_x255", 64'(exp_q[254]), 254);
      run_frame(512, 2, 0, -1);
      chk("ramp_n", 64'(got_q.size()), 511);
      chk("ramp_x255", 64'(got_q[254]), 254);
      chk("ramp_x256", 64'(got_q[255]), 254);
      chk("ramp_x257", 64'(got_q[256]), 2);

      rnd_ready = 1;
      for (int r = 0; r < 6; r++) begin
         w = $urandom_range(24, 2);
         h = $urandom_range(8, 2);
         pix.delete();
         for (int i = 0; i < w*h; i++)
            pix.push_back($urandom_range(3) == 0 ?
                          ($urandom_range(1) == 1 ? 255 : 0) :
                          $urandom_range(255));
         gen_expected(w, h);
         run_frame(w, h, 1, -1);
      end
      rnd_ready = 0;

      repeat (5) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_dataflow_roberts_mdc_engine.md
# multi_dataflow_roberts_mdc_engine

Streaming Roberts-cross edge-detection engine between the roberts_mdc streamer's engine-side ports. It consumes one frame-size word on `in_size`, then a raster-ordered pixel stream on `in_pel`. It produces a saturated gradient magnitude on `out_pel` for every pixel with x≥1 and y≥1. The previous image row is held in an internal line buffer; start, busy, done and error are exchanged with the controller through package structs.

## Interface
Parameters:
- `MAX_WIDTH`, 512: maximum supported frame width in pixels; sets line-buffer depth.
- `PEL_WIDTH`, 8: pixel bit width, carried in bits [PEL_WIDTH-1:0] of each 32-bit stream word.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `test_mode_i` in 1: unused; reserved.
- `enable_i` in 1: local enable; low freezes all state.
- `clear_i` in 1: synchronous soft clear, same effect as reset.
- `in_size` hwpe_stream_intf_stream.sink, 32: size word; [15:0] = width W, [31:16] = height H.
- `in_pel` hwpe_stream_intf_stream.sink, 32: input pixels.
- `out_pel` hwpe_stream_intf_stream.source, 32: gradient, zero-extended.
- `ctrl_i` in `ctrl_engine_multi_dataflow_roberts_mdc_t`: field `start` (1-cycle pulse).
- `flags_o` out `flags_engine_multi_dataflow_roberts_mdc_t`: fields `busy`, `done`, `err`, `out_cnt[31:0]`.

## Operation
- FSM states:
  - IDLE: on `start` → SIZE.
  - SIZE: `in_size.ready`=1; on handshake, latch W and H. If 2≤W≤MAX_WIDTH and H≥2 → RUN; otherwise set `err`=1 → DONE.
  - RUN: accept pixels; the handshake of the last pixel (x=W-1, y=H-1) → DRAIN.
  - DRAIN: wait for the output register to empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Counters x ∈ [0,W-1] and y ∈ [0,H-1] advance on each `in_pel` handshake. x wraps to 0 and y increments at x=W-1.
- Line buffer `lb[x]` holds the previous row. On each accepted pixel p at column x:
  - read `up = lb[x]` (read-before-write);
  - write `lb[x] = p`;
  - `up_left` register ← `up`;
  - `left` register ← `p`.
- When x≥1 and y≥1, compute G = |p − up_left| + |left − up| using 9-bit signed differences and a 10-bit sum, saturated to 2^PEL_WIDTH−1. G is loaded into the output register and `out_cnt` increments.
- Pixels with x=0 or y=0 update state only and produce no output. Total outputs per frame = (W−1)(H−1).
- `err` is sticky until the next `start`. `start` outside IDLE is ignored.
- `busy` = state ≠ IDLE.
- `in_pel.ready` = `enable_i` & RUN & (¬out_valid | `out_pel.ready`).
- `enable_i`=0:
  - all readies are 0;
  - the FSM, counters and buffer are held;
  - `out_pel.valid` and data stay unchanged.

## Timing
- Reset and clear values:
  - state IDLE, x=y=0;
  - `out_pel.valid`=0, `out_pel.data`=0;
  - all `flags_o` fields 0;
  - `in_size.ready`=0, `in_pel.ready`=0.
  - Line-buffer contents are don't-care.
- Latency: `out_pel.valid` rises the cycle after the producing `in_pel` handshake.
- Throughput: one pixel per cycle under full readiness, because output load and drain can occur in the same cycle.
- Output handshake:
  - valid and data stay stable until the `out_pel.ready` handshake;
  - valid never drops without a handshake unless reset or clear is applied;
  - `strb` is all ones.
- `done` is asserted in the cycle after DRAIN observes an empty output register. For an invalid size it is asserted the cycle after the `in_size` handshake.
- Reset or clear mid-frame:
  - return to IDLE next cycle;
  - the pending output is discarded;
  - no `done` is emitted;
  - unconsumed input words stay in the upstream FIFOs.

## Structure
- `multi_dataflow_roberts_mdc_package` gains:
  - `ctrl_engine_multi_dataflow_roberts_mdc_t`;
  - `flags_engine_multi_dataflow_roberts_mdc_t`;
  - an FSM state enum;
  - constant `ROBERTS_MAX_WIDTH` = 512.
- Sub-module `multi_dataflow_roberts_mdc_line_buffer`: MAX_WIDTH×PEL_WIDTH flip-flop array, one port with combinational read and a write enable, no reset on contents.

## Test plan
- 3×3 frame, p(x,y)=3y+x, all readies high → exactly 4 outputs, all value 6, then `done` pulse; `out_cnt`=4.
- 2×2 frame rows [0,0],[255,255] → a single output of 255 (510 saturated); `err`=0.
- Size word W=1, H=5 → `err`=1, `done` one cycle after the handshake, `in_pel.ready` never asserted.
- 3×3 frame with `out_pel.ready` low for 5 cycles mid-frame → valid and data held, `in_pel.ready` low, output sequence identical to the unstalled run.
- `clear_i` pulsed after 4 pixels of a 4×4 frame, then a new 3×3 start → IDLE, `busy`=0, no `done` for the aborted frame; the 3×3 frame yields 4×6.
- W=MAX_WIDTH, H=2 ramp frame p(x,0)=x mod 256, p(x,1)=(x+1) mod 256 → MAX_WIDTH−1 outputs; check values at the wrap columns x=255 and x=256.
